// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regs
// Brief    : I2C target exposing a byte-wide register file (pointer + burst
//            write, current-address burst read) to an external initiator.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter bit         ADDR_2BYTE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEV    = 3'd1,
        S_ADDR_H = 3'd2,
        S_ADDR_L = 3'd3,
        S_WR     = 3'd4,
        S_RD     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_scl_sync;
    logic [1:0]  r_sda_sync;
    logic        r_scl_prev;
    logic        r_sda_prev;
    logic [3:0]  r_cnt;
    logic        r_ack;
    logic        r_sda_low;
    logic [7:0]  r_rx;
    logic [7:0]  r_tx;
    logic        r_we_pend;
    logic        r_rd_load;

    logic        w_scl;
    logic        w_sda;
    logic        w_rise;
    logic        w_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_byte_done;
    logic [7:0]  w_byte;
    logic        w_match;
    logic        w_ack_begin;
    logic        w_ack_end;
    logic        w_ack_sample;
    logic [15:0] w_ptr_inc;

    // Open-drain: only ever pull low, the bus pull-up provides the high level
    assign i2c_sda = r_sda_low ? 1'b0 : 1'bz;

    assign w_scl        = r_scl_sync[1];
    assign w_sda        = r_sda_sync[1];
    assign w_rise       = w_scl & ~r_scl_prev;
    assign w_fall       = ~w_scl & r_scl_prev;
    assign w_start      = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop       = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_byte_done  = w_rise & (r_cnt == 4'd7);
    assign w_byte       = {r_rx[6:0], w_sda};
    assign w_match      = (w_byte[7:1] == DEV_ADDR);
    // r_ack separates the 8th falling edge (ACK begins) from the 9th (ACK ends)
    assign w_ack_begin  = w_fall & (r_cnt == 4'd8) & ~r_ack;
    assign w_ack_end    = w_fall & r_ack;
    assign w_ack_sample = w_rise & (r_cnt == 4'd8) & (r_state == S_RD);
    assign w_ptr_inc    = ADDR_2BYTE ? (reg_addr + 16'd1)
                                     : {8'h00, reg_addr[7:0] + 8'd1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = S_IDLE;
        end else if (w_start) begin
            w_state_next = S_DEV;
        end else begin
            case (r_state)
                S_DEV: begin
                    if (w_byte_done && !w_match) begin
                        w_state_next = S_IDLE;
                    end else if (w_ack_end) begin
                        if (r_rx[0]) begin
                            w_state_next = S_RD;
                        end else begin
                            w_state_next = ADDR_2BYTE ? S_ADDR_H : S_ADDR_L;
                        end
                    end
                end
                S_ADDR_H: if (w_ack_end) w_state_next = S_ADDR_L;
                S_ADDR_L: if (w_ack_end) w_state_next = S_WR;
                S_RD:     if (w_ack_sample && w_sda) w_state_next = S_IDLE;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_cnt      <= 4'd0;
            r_ack      <= 1'b0;
            r_sda_low  <= 1'b0;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_we_pend  <= 1'b0;
            r_rd_load  <= 1'b0;
            reg_addr   <= 16'h0000;
            reg_wdata  <= 8'h00;
            reg_we     <= 1'b0;
            reg_rd     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl};
            r_sda_sync <= {r_sda_sync[0], i2c_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;

            r_we_pend  <= 1'b0;
            reg_we     <= r_we_pend;
            reg_rd     <= 1'b0;
            r_rd_load  <= reg_rd;
            if (r_we_pend) reg_wdata <= r_rx;
            if (r_rd_load) r_tx <= reg_rdata;
            if (reg_we) reg_addr <= w_ptr_inc;

            if (w_state_next == S_IDLE) begin
                busy <= 1'b0;
            end else if (r_state == S_DEV && w_byte_done && w_match) begin
                busy <= 1'b1;
            end

            if (w_start || w_stop || r_state == S_IDLE) begin
                r_cnt     <= 4'd0;
                r_ack     <= 1'b0;
                r_sda_low <= 1'b0;
            end else begin
                if (w_rise && r_cnt < 4'd8) begin
                    r_rx  <= w_byte;
                    r_tx  <= {r_tx[6:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        S_DEV:    if (w_match && w_byte[0]) reg_rd <= 1'b1;
                        S_ADDR_H: reg_addr[15:8] <= w_byte;
                        S_ADDR_L: reg_addr[7:0]  <= w_byte;
                        S_WR:     r_we_pend <= 1'b1;
                        default:  ;
                    endcase
                end
                if (w_ack_sample && !w_sda) begin
                    reg_addr <= w_ptr_inc;
                    reg_rd   <= 1'b1;
                end
                if (w_ack_begin) begin
                    r_ack     <= 1'b1;
                    r_sda_low <= (r_state != S_RD);
                end else if (w_ack_end) begin
                    // Leaving the ACK slot: release, or present the next read MSB
                    r_ack     <= 1'b0;
                    r_cnt     <= 4'd0;
                    r_sda_low <= (w_state_next == S_RD) & ~r_tx[7];
                end else if (w_fall && r_state == S_RD && r_cnt != 4'd0 && r_cnt < 4'd8) begin
                    r_sda_low <= ~r_tx[7];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regs
// Brief    : Bit-banged I2C initiator with a strobe scoreboard for i2c_slave_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regs;

    localparam int Q = 100;

    typedef struct packed {
        logic        inst;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sel = 1'b0;
    logic        scl0, scl1, sda_rd;
    wire         sda0, sda1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        we0, we1, rd0, rd1, busy0, busy1;
    logic [7:0]  rdata0 = 8'h00;
    logic [7:0]  rdata1 = 8'h00;
    logic [7:0]  bank [256];
    ev_t         exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pullup (sda0);
    pullup (sda1);
    assign sda0   = (!sel && !sda_m) ? 1'b0 : 1'bz;
    assign sda1   = ( sel && !sda_m) ? 1'b0 : 1'bz;
    assign scl0   = sel ? 1'b1 : scl;
    assign scl1   = sel ? scl : 1'b1;
    assign sda_rd = sel ? sda1 : sda0;

    i2c_slave_regs #(.DEV_ADDR(7'h3C), .ADDR_2BYTE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .i2c_scl(scl0), .i2c_sda(sda0),
        .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0), .reg_rd(rd0),
        .reg_rdata(rdata0), .busy(busy0)
    );

    i2c_slave_regs #(.DEV_ADDR(7'h3C), .ADDR_2BYTE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .i2c_scl(scl1), .i2c_sda(sda1),
        .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_rd(rd1),
        .reg_rdata(rdata1), .busy(busy1)
    );

    // Register bank model answering read strobes on the following cycle
    always @(posedge clk) begin
        if (rd0) rdata0 <= bank[addr0[7:0]];
        if (rd1) rdata1 <= bank[addr1[7:0]];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void exp_wr(input logic inst, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{inst: inst, wr: 1'b1, addr: a, data: d});
    endfunction

    function automatic void exp_rd(input logic inst, input logic [15:0] a);
        exp_q.push_back('{inst: inst, wr: 1'b0, addr: a, data: 8'h00});
    endfunction

    function automatic void observe(input logic inst, input logic we, input logic rd,
                                    input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        if (we && rd) check("we_rd_exclusive", 32'(we & rd), 32'd0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe inst=%0d we=%0d addr=%0h data=%0h required=none",
                     inst, we, a, d);
        end else begin
            e = exp_q.pop_front();
            check("strobe_inst", 32'(inst), 32'(e.inst));
            check("strobe_kind_we", 32'(we), 32'(e.wr));
            check("strobe_addr", 32'(a), 32'(e.addr));
            if (e.wr) check("strobe_wdata", 32'(d), 32'(e.data));
        end
    endfunction

    always @(negedge clk) begin
        if (we0 || rd0) observe(1'b0, we0, rd0, addr0, wdata0);
        if (we1 || rd1) observe(1'b1, we1, rd1, addr1, wdata1);
    end

    task automatic start_c();
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic stop_c();
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        end
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        send_bits(b, 8);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; a = sda_rd; #Q; scl = 1'b0; #Q;
        check(name, 32'(a), 32'(exp_ack));
    endtask

    task automatic rd_byte(output logic [7:0] b, input logic m_ack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl = 1'b1; #Q; b[i] = sda_rd; #Q; scl = 1'b0; #Q;
        end
        sda_m = m_ack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; sda_m = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        for (int i = 0; i < 256; i++) bank[i] = 8'h00;
        bank[8'h20] = 8'h5A;
        bank[8'h21] = 8'hC3;

        repeat (5) @(posedge clk);
        #1;
        check("rst_sda", 32'(sda0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_we", 32'(we0), 32'd0);
        check("rst_rd", 32'(rd0), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single write, 8-bit pointer
        exp_wr(1'b0, 16'h0010, 8'hA5);
        start_c();
        wr_byte(8'h78, 1'b0, "t1_ack_dev");
        check("t1_busy", 32'(busy0), 32'd1);
        wr_byte(8'h10, 1'b0, "t1_ack_reg");
        wr_byte(8'hA5, 1'b0, "t1_ack_data");
        stop_c();
        #Q;
        check("t1_busy_after_stop", 32'(busy0), 32'd0);

        // Burst write wrapping at 0xFF
        exp_wr(1'b0, 16'h00FE, 8'h11);
        exp_wr(1'b0, 16'h00FF, 8'h22);
        exp_wr(1'b0, 16'h0000, 8'h33);
        start_c();
        wr_byte(8'h78, 1'b0, "t2_ack_dev");
        wr_byte(8'hFE, 1'b0, "t2_ack_reg");
        wr_byte(8'h11, 1'b0, "t2_ack_d0");
        wr_byte(8'h22, 1'b0, "t2_ack_d1");
        wr_byte(8'h33, 1'b0, "t2_ack_d2");
        stop_c();
        check("t2_ptr_wrap", 32'(addr0), 32'h0001);

        // Random read through repeated start
        exp_rd(1'b0, 16'h0020);
        exp_rd(1'b0, 16'h0021);
        start_c();
        wr_byte(8'h78, 1'b0, "t3_ack_dev_w");
        wr_byte(8'h20, 1'b0, "t3_ack_reg");
        start_c();
        wr_byte(8'h79, 1'b0, "t3_ack_dev_r");
        rd_byte(rb, 1'b0);
        check("t3_rdata0", 32'(rb), 32'h5A);
        rd_byte(rb, 1'b1);
        check("t3_rdata1", 32'(rb), 32'hC3);
        #Q;
        check("t3_idle_after_nack", 32'(busy0), 32'd0);
        stop_c();
        check("t3_ptr", 32'(addr0), 32'h0021);

        // Address mismatch: no ACK, no strobes, never busy
        start_c();
        wr_byte(8'h7A, 1'b1, "t4_nack_dev");
        check("t4_busy0", 32'(busy0), 32'd0);
        wr_byte(8'h10, 1'b1, "t4_nack_d0");
        wr_byte(8'h00, 1'b1, "t4_nack_d1");
        check("t4_busy1", 32'(busy0), 32'd0);
        stop_c();

        // 16-bit pointer instance
        sel = 1'b1;
        #Q;
        exp_wr(1'b1, 16'h1234, 8'h99);
        start_c();
        wr_byte(8'h78, 1'b0, "t5_ack_dev");
        wr_byte(8'h12, 1'b0, "t5_ack_hi");
        wr_byte(8'h34, 1'b0, "t5_ack_lo");
        wr_byte(8'h99, 1'b0, "t5_ack_data");
        stop_c();
        check("t5_ptr", 32'(addr1), 32'h1235);
        sel = 1'b0;
        #Q;

        // STOP after 4 bits of a data byte
        start_c();
        wr_byte(8'h78, 1'b0, "t6_ack_dev");
        wr_byte(8'h40, 1'b0, "t6_ack_reg");
        send_bits(8'hF0, 4);
        stop_c();
        #Q;
        check("t6_busy", 32'(busy0), 32'd0);
        check("t6_ptr", 32'(addr0), 32'h0040);

        // Reset while the target drives ACK
        start_c();
        wr_byte(8'h78, 1'b0, "t7_ack_dev");
        send_bits(8'h66, 8);
        sda_m = 1'b1;
        #50;
        check("t7_ack_driven", 32'(sda0), 32'd0);
        rst = 1'b1;
        #1;
        check("t7_sda_released", 32'(sda0), 32'd1);
        check("t7_busy", 32'(busy0), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t7_ptr_reset", 32'(addr0), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        stop_c();

        // Normal transaction after the reset
        exp_wr(1'b0, 16'h0005, 8'h77);
        start_c();
        wr_byte(8'h78, 1'b0, "t8_ack_dev");
        wr_byte(8'h05, 1'b0, "t8_ack_reg");
        wr_byte(8'h77, 1'b0, "t8_ack_data");
        stop_c();
        check("t8_ptr", 32'(addr0), 32'h0006);

        #(2*Q);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (responder) that exposes a byte-wide register file to an external I2C initiator: it decodes START/STOP, matches a 7-bit device address, and accepts register-address-then-data writes and current-address reads. It is the responder counterpart of our I2C config initiator and sits between the board I2C pins and any local register bank. It is used for loopback verification of the config path and for host-writable control registers.

## Interface

- DEV_ADDR, 7'h3C, 7-bit device address this target answers to.
- ADDR_2BYTE, 0, 1 = 16-bit register address sent MSB first; 0 = 8-bit address.
- clk  in  1  system clock; must be >= 20x SCL frequency.
- rst  in  1  reset, asynchronous, active-high.
- i2c_scl  in  1  SCL line; no clock stretching.
- i2c_sda  inout  1  SDA line; driven low only, released to 1'bz otherwise.
- reg_addr  out  16  current register pointer; upper 8 bits are 0 when ADDR_2BYTE=0.
- reg_wdata  out  8  write data, valid while reg_we=1.
- reg_we  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe; reg_rdata must be valid on the next clk.
- reg_rdata  in  8  read data from the register bank.
- busy  out  1  high from an addressed START to STOP, NACK, or mismatch.

## Operation

- SCL and SDA pass through 2-flop synchronizers; edges are detected on the synchronized copies.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bits are sampled on SCL rising edges, MSB first.
- SDA changes only after an SCL falling edge. ACK drive begins after the 8th falling edge and is released after the 9th falling edge.
- States:
  - IDLE -> DEV on START.
  - DEV: shift 8 bits, then:
    - address match, R/W=0 -> ACK, then ADDR_H (ADDR_2BYTE=1) or ADDR_L.
    - address match, R/W=1 -> ACK, pulse reg_rd, then RD.
    - mismatch -> no ACK, IDLE.
  - ADDR_H/ADDR_L: shift a byte into the pointer, ACK, then next address byte or WR.
  - WR: shift 8 bits -> ACK. One cycle after the 8th rising edge: reg_we=1 and reg_wdata=byte at the current pointer. The pointer increments the cycle after reg_we.
  - RD: shift register loads reg_rdata on the cycle after reg_rd. Drive bits (0 = pull low, 1 = release). On the 9th rising edge sample the master ACK:
    - ACK (0): increment pointer, pulse reg_rd, stay RD.
    - NACK (1): IDLE.
- A START in any state (repeated start) -> DEV. The pointer is kept, so write-address-then-read works.
- A STOP in any state -> IDLE, SDA released, busy=0. A partial byte is discarded and no reg_we is issued.
- The pointer wraps modulo 2^8 (ADDR_2BYTE=0) or 2^16.
- A bit counter (0..8) is cleared on START and after every ACK slot.

## Timing

- Reset values: SDA released, reg_we=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, state IDLE. Reset releases SDA asynchronously, including mid-transfer.
- Synchronizer plus edge-detect latency: 3 clk from the pin to the internal edge pulse.
- reg_we asserts 4 clk after the SCL rising edge of data bit 0 (LSB) at the pin.
- reg_rd to reg_rdata capture: 1 clk. reg_rd is issued at least 9 clk before the first SCL falling edge that needs the data.
- reg_we and reg_rd are never asserted in the same cycle, and each is asserted at most once per byte.

## Test plan

- Write, 8-bit address: START, 0x78, 0x10, 0xA5, STOP -> three ACKs, a single reg_we with reg_addr=0x10 and reg_wdata=0xA5, busy falls after STOP.
- Burst write with wrap: 0x78, 0xFE, 0x11, 0x22, 0x33 -> writes at 0xFE, 0xFF, 0x00.
- Random read: 0x78, 0x20, Sr, 0x79, then two bytes with bank returning 0x5A, 0xC3 (master ACK then NACK) -> SDA carries 0x5A then 0xC3, reg_rd at 0x20 and 0x21, state IDLE after NACK.
- Address mismatch: 0x7A then data bytes -> SDA never driven low, no strobes, busy=0.
- ADDR_2BYTE=1: 0x78, 0x12, 0x34, 0x99 -> reg_we at 0x1234 with data 0x99.
- STOP after 4 bits of a data byte, and rst mid-ACK -> no reg_we, SDA released immediately, next transaction completes normally.
